// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Provides a start/busy/done handshake, overflow saturation and a leading-zero mask.
module bin2bcd_seq #(
    parameter int unsigned IN_W   = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(IN_W + 1);

    localparam logic [CW-1:0]     LAST_CNT  = CW'(IN_W - 1);
    localparam logic [BW-1:0]     ALL_NINES = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0] LZ_RESET  = {DIGITS{1'b1}} ^ DIGITS'(1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [IN_W-1:0]     shreg_q, shreg_d;
    logic [BW-1:0]       scratch_q, scratch_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic                overflow_q, overflow_d;
    logic [DIGITS-1:0]   lz_q, lz_d;

    logic [BW-1:0]       adj;
    logic [BW+IN_W-1:0]  shifted;

    // Bit i set when digits DIGITS-1..i are all zero; digit 0 is never masked.
    function automatic logic [DIGITS-1:0] lz_of(input logic [BW-1:0] v);
        logic              run;
        logic [DIGITS-1:0] m;
        m   = '0;
        run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            run  = run & (v[4*i +: 4] == 4'd0);
            m[i] = run;
        end
        return m;
    endfunction

    // Per-digit add-3 correction, no carry between digits.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, shreg_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        lz_d       = lz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d   = number;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = shifted[BW+IN_W-1:IN_W];
                shreg_d   = shifted[IN_W-1:0];
                // A set bit leaving the top digit means the value no longer fits.
                if (adj[BW-1]) begin
                    ovf_d = 1'b1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d     = 1'b1;
                overflow_d = ovf_q;
                bcd_d      = ovf_q ? ALL_NINES : scratch_q;
                lz_d       = ovf_q ? '0 : lz_of(scratch_q);
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            lz_q       <= LZ_RESET;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            lz_q       <= lz_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;
    assign lz_mask  = lz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 10-bit and a 14-bit instance, both with 4 digits, checked
// against an arithmetic decimal model.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset_n;

    logic        start_a, start_b;
    logic [9:0]  number_a;
    logic [13:0] number_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [15:0] bcd_a, bcd_b;
    logic [3:0]  lz_a, lz_b;

    int n_checks = 0;
    int n_pass   = 0;
    int seen_a   = 0;
    int seen_b   = 0;
    int exp_a    = 0;
    int exp_b    = 0;

    bin2bcd_seq #(.IN_W(10), .DIGITS(4)) u_dut_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_a),
        .number   (number_a),
        .busy     (busy_a),
        .done     (done_a),
        .bcd      (bcd_a),
        .overflow (ovf_a),
        .lz_mask  (lz_a)
    );

    bin2bcd_seq #(.IN_W(14), .DIGITS(4)) u_dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_b),
        .number   (number_b),
        .busy     (busy_b),
        .done     (done_b),
        .bcd      (bcd_b),
        .overflow (ovf_b),
        .lz_mask  (lz_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_a) seen_a++;
        if (done_b) seen_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Decimal reference: saturate at 10**4, digit i of n, leading zero where n < 10**i.
    task automatic model(input int unsigned n, output logic [15:0] b, output logic ov,
                         output logic [3:0] lz);
        int unsigned v;
        int unsigned p;
        b  = '0;
        lz = '0;
        if (n >= 10000) begin
            ov = 1'b1;
            b  = 16'h9999;
        end else begin
            ov = 1'b0;
            v  = n;
            for (int i = 0; i < 4; i++) begin
                b[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
            p = 10;
            for (int i = 1; i < 4; i++) begin
                lz[i] = (n < p);
                p = p * 10;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic conv(input bit sel, input int unsigned n, input bit noise);
        int          cyc;
        int          lat;
        bit          busy_low;
        logic [15:0] eb;
        logic        eo;
        logic [3:0]  el;
        lat = sel ? 15 : 11;
        model(n, eb, eo, el);
        if (sel) begin start_b = 1'b1; number_b = 14'(n); end
        else     begin start_a = 1'b1; number_a = 10'(n); end
        @(posedge clk);
        @(negedge clk);
        start_a  = 1'b0;
        start_b  = 1'b0;
        number_a = 10'($urandom);
        number_b = 14'($urandom);
        cyc      = 0;
        busy_low = 1'b0;
        while (!(sel ? done_b : done_a) && cyc < 60) begin
            if (!(sel ? busy_b : busy_a)) busy_low = 1'b1;
            if (noise && (cyc == 2 || cyc == 10)) begin
                if (sel) begin start_b = 1'b1; number_b = 14'd999; end
                else     begin start_a = 1'b1; number_a = 10'd999; end
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
        end
        if (sel) exp_b++; else exp_a++;
        check("latency", cyc, lat);
        check("busy_held", 32'(busy_low), 32'd0);
        check("busy_at_done", 32'(sel ? busy_b : busy_a), 32'd0);
        check("bcd", 32'(sel ? bcd_b : bcd_a), 32'(eb));
        check("overflow", 32'(sel ? ovf_b : ovf_a), 32'(eo));
        check("lz_mask", 32'(sel ? lz_b : lz_a), 32'(el));
    endtask

    task automatic check_reset_state();
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_bcd_a", 32'(bcd_a), 32'd0);
        check("rst_ovf_a", 32'(ovf_a), 32'd0);
        check("rst_lz_a", 32'(lz_a), 32'h0e);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_bcd_b", 32'(bcd_b), 32'd0);
        check("rst_lz_b", 32'(lz_b), 32'h0e);
    endtask

    initial begin
        int s;
        reset_n  = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        number_a = '0;
        number_b = '0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases, including a start in the cycle right after done.
        conv(1'b0, 255, 1'b0);
        conv(1'b0, 0, 1'b0);
        conv(1'b0, 1023, 1'b0);
        conv(1'b0, 7, 1'b0);
        @(negedge clk);

        // Start re-asserted while busy must be ignored.
        conv(1'b0, 100, 1'b1);
        @(negedge clk);
        #1 s = seen_a;
        repeat (20) @(negedge clk);
        #1 check("no_extra_done", 32'(seen_a - s), 32'd0);
        check("idle_after_ignore", 32'(busy_a), 32'd0);

        conv(1'b1, 9999, 1'b0);
        conv(1'b1, 10000, 1'b0);
        conv(1'b1, 16383, 1'b0);
        conv(1'b1, 10, 1'b0);

        for (int i = 0; i < 15; i++) conv(1'b0, $urandom_range(0, 1023), 1'b0);
        for (int i = 0; i < 15; i++) conv(1'b1, $urandom_range(0, 16383), 1'b0);

        // Reset in cycle 5 of a conversion aborts it.
        @(negedge clk);
        start_a  = 1'b1;
        number_a = 10'd512;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_state();
        #1 s = seen_a;
        repeat (20) @(negedge clk);
        #1 check("abort_no_done", 32'(seen_a - s), 32'd0);
        conv(1'b0, 512, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        check("done_count_a", 32'(seen_a), 32'(exp_a));
        check("done_count_b", 32'(seen_b), 32'(exp_b));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
